// File: rtl/input_debounce_sync_pkg.sv
// Shared definitions for the input_controller front end: parameter defaults,
// counter sizing and the per-channel status record used by the register map.
package input_ctrl_pkg;

  localparam int NUM_INPUTS_DEF      = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

  // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic flag;
  } chan_status_t;

endpackage

// File: rtl/input_debounce_sync_channel.sv
// One input channel: 2-flop synchronizer, hold counter, debounced level and
// registered edge pulses. rise_set_o announces the rise one edge ahead.
module debounce_channel
  import input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_set_o
);

  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Any return of sync2 to the accepted level restarts the hold window.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = sync2_q;
      rise_d  = sync2_q;
      fall_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign rise_set_o = rise_d;

endmodule

// File: rtl/input_debounce_sync.sv
// Debounce/synchronize NUM_INPUTS raw inputs; keeps sticky W1C event flags
// that set on the same edge as the rise pulse, and an irq derived from them.
module input_debounce_sync
  import input_ctrl_pkg::*;
#(
  parameter int NUM_INPUTS      = NUM_INPUTS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [NUM_INPUTS-1:0] raw_in,
  input  logic                  clr_valid,
  input  logic [NUM_INPUTS-1:0] clr_mask,
  output logic [NUM_INPUTS-1:0] level_out,
  output logic [NUM_INPUTS-1:0] rise_pulse,
  output logic [NUM_INPUTS-1:0] fall_pulse,
  output logic [NUM_INPUTS-1:0] event_flags,
  output logic                  irq
);

  chan_status_t          status [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] level_w, rise_w, fall_w, rise_set;
  logic [NUM_INPUTS-1:0] flags_q, flags_d;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i     (ACLK),
      .rst_i     (ARESET),
      .raw_i     (raw_in[gi]),
      .level_o   (level_w[gi]),
      .rise_o    (rise_w[gi]),
      .fall_o    (fall_w[gi]),
      .rise_set_o(rise_set[gi])
    );

    assign status[gi]      = '{level: level_w[gi], rise: rise_w[gi],
                               fall: fall_w[gi], flag: flags_q[gi]};
    assign level_out[gi]   = status[gi].level;
    assign rise_pulse[gi]  = status[gi].rise;
    assign fall_pulse[gi]  = status[gi].fall;
    assign event_flags[gi] = status[gi].flag;
  end

  // Set is OR-ed in after the clear so a coincident rise is never lost.
  always_comb begin
    flags_d = (flags_q & ~({NUM_INPUTS{clr_valid}} & clr_mask)) | rise_set;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  always_comb begin
    irq = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      irq = irq | status[i].flag;
    end
  end

endmodule

// File: tb/tb_input_debounce_sync.sv
// Directed bench for input_debounce_sync with DEBOUNCE_CYCLES=4, 8 inputs.
module tb_input_debounce_sync;

  localparam int N = 8;
  localparam int D = 4;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [N-1:0] raw_in;
  logic         clr_valid;
  logic [N-1:0] clr_mask;
  logic [N-1:0] level_out, rise_pulse, fall_pulse, event_flags;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 ACLK = ~ACLK;

  input_debounce_sync #(
    .NUM_INPUTS     (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .raw_in     (raw_in),
    .clr_valid  (clr_valid),
    .clr_mask   (clr_mask),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .event_flags(event_flags),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One active edge, then settle 1 ns past it before sampling/driving.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] lvl, input logic [N-1:0] rp,
                           input logic [N-1:0] fp, input logic [N-1:0] fl, input logic iq);
    check({tag, ".level"}, 32'(level_out), 32'(lvl));
    check({tag, ".rise"},  32'(rise_pulse), 32'(rp));
    check({tag, ".fall"},  32'(fall_pulse), 32'(fp));
    check({tag, ".flags"}, 32'(event_flags), 32'(fl));
    check({tag, ".irq"},   32'(irq), 32'(iq));
  endtask

  initial begin
    ARESET    = 1'b1;
    raw_in    = '0;
    clr_valid = 1'b0;
    clr_mask  = '0;
    #1;
    tick(3);
    check_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    ARESET = 1'b0;
    tick(2);

    // Clean press on channel 0: level after the 6th edge (edge 5).
    raw_in[0] = 1'b1;
    tick(5);
    check_all("press_pre", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick(1);
    check_all("press_edge", 8'h01, 8'h01, 8'h00, 8'h01, 1'b1);
    tick(1);
    check_all("press_after", 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);

    // Glitch on channel 3 for D-1 cycles never propagates.
    raw_in[3] = 1'b1;
    tick(3);
    raw_in[3] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("glitch.level", 32'(level_out), 32'h01);
      check("glitch.rise",  32'(rise_pulse), 32'h00);
    end
    check("glitch.flags", 32'(event_flags), 32'h01);

    // Release channel 0: fall pulse after edge 5, flag stays.
    raw_in[0] = 1'b0;
    tick(5);
    check_all("release_pre", 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);
    tick(1);
    check_all("release_edge", 8'h00, 8'h00, 8'h01, 8'h01, 1'b1);
    tick(1);
    check_all("release_after", 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);

    // W1C: non-matching mask leaves the flag, matching mask clears it.
    clr_valid = 1'b1;
    clr_mask  = 8'h02;
    tick(1);
    check("w1c_other.flags", 32'(event_flags), 32'h01);
    check("w1c_other.irq",   32'(irq), 32'h1);
    clr_mask = 8'h01;
    tick(1);
    clr_valid = 1'b0;
    clr_mask  = '0;
    check("w1c.flags", 32'(event_flags), 32'h00);
    check("w1c.irq",   32'(irq), 32'h0);

    // Set/clear collision on channel 5: set wins.
    raw_in[5] = 1'b1;
    tick(5);
    check("coll_pre.level", 32'(level_out), 32'h00);
    clr_valid = 1'b1;
    clr_mask  = 8'h20;
    tick(1);
    clr_valid = 1'b0;
    clr_mask  = '0;
    check_all("collision", 8'h20, 8'h20, 8'h00, 8'h20, 1'b1);

    // Reset mid-count on channel 7 (channel 5 still held high).
    raw_in[7] = 1'b1;
    tick(3);
    ARESET = 1'b1;
    tick(1);
    check_all("midreset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    ARESET = 1'b0;
    tick(5);
    check_all("postreset_pre", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick(1);
    check_all("postreset_edge", 8'hA0, 8'hA0, 8'h00, 8'hA0, 1'b1);
    tick(1);
    check_all("postreset_after", 8'hA0, 8'h00, 8'h00, 8'hA0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
